// File: rtl/i2s_dac_tx_if.sv
// Sample handshake between the upstream filter output and the I2S DAC serializer.
// The master drives a left/right pair with valid; the slave returns ready.
interface i2s_dac_tx_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC master: divides sample_clock into BCLK/LRCK and shifts one buffered left/right
// pair per frame out on dac_data, MSB first, one BCLK after each LRCK edge.
module i2s_dac_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned BCLK_DIV  = 6
) (
    input  logic        sample_clock,
    input  logic        reset,
    input  logic        enable,
    i2s_dac_tx_if.slave smp,
    output logic        dac_bclk,
    output logic        dac_lrck,
    output logic        dac_data,
    output logic        frame_start,
    output logic        underflow
);
    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_FIRST = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic                  primed;
    logic [FRAME_BITS-1:0] frame_sr;
    logic [FRAME_BITS-1:0] load_word;
    logic [DATA_W-1:0]     buf_left;
    logic [DATA_W-1:0]     buf_right;
    logic                  buf_full;
    logic                  fall;
    logic                  load;
    logic                  capture;

    assign smp.sample_ready = ~buf_full;
    assign capture          = smp.sample_valid & ~buf_full;
    assign fall             = enable & dac_bclk & (div_cnt == DIV_LAST);
    // The first fall after enable/reset begins a frame instead of advancing bit_cnt.
    assign load             = fall & (~primed | (bit_cnt == BIT_LAST));
    assign bit_nxt          = bit_cnt + 1'b1;

    always_comb begin
        load_word = '0;
        if (buf_full) begin
            load_word[FRAME_BITS-1 -: DATA_W] = buf_left;
            load_word[SLOT_BITS-1 -: DATA_W]  = buf_right;
        end
    end

    always_ff @(posedge sample_clock) begin
        frame_start <= 1'b0;
        underflow   <= 1'b0;
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            primed    <= 1'b0;
            frame_sr  <= '0;
            buf_left  <= '0;
            buf_right <= '0;
            buf_full  <= 1'b0;
            dac_bclk  <= 1'b0;
            dac_lrck  <= 1'b0;
            dac_data  <= 1'b0;
        end else begin
            // A capture only happens with the buffer empty, so it wins over a load's clear.
            if (capture) begin
                buf_left  <= smp.sample_left;
                buf_right <= smp.sample_right;
                buf_full  <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (!enable) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                primed   <= 1'b0;
                frame_sr <= '0;
                dac_bclk <= 1'b0;
                dac_lrck <= 1'b0;
                dac_data <= 1'b0;
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt  <= '0;
                    dac_bclk <= ~dac_bclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end

                if (load) begin
                    // After 2*SLOT_BITS-1 shifts the MSB holds the previous frame's last bit.
                    dac_data    <= frame_sr[FRAME_BITS-1];
                    frame_sr    <= load_word;
                    bit_cnt     <= '0;
                    dac_lrck    <= 1'b0;
                    primed      <= 1'b1;
                    frame_start <= 1'b1;
                    underflow   <= ~buf_full;
                end else if (fall) begin
                    dac_data <= frame_sr[FRAME_BITS-1];
                    frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
                    bit_cnt  <= bit_nxt;
                    dac_lrck <= (bit_nxt >= SLOT_FIRST);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: random pairs, an I2S receiver model and a one-entry
// buffer scoreboard predict every frame, ready level, underflow pulse and frame timing.
module tb_i2s_dac_tx;
    localparam int D         = 16;
    localparam int S         = 16;
    localparam int DIV       = 6;
    localparam int FB        = 2 * S;
    localparam int FRAME_CYC = FB * 2 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic bclk, lrck, data, fs, uf;

    i2s_dac_tx_if #(.DATA_W(D)) smp ();

    i2s_dac_tx #(.DATA_W(D), .SLOT_BITS(S), .BCLK_DIV(DIV)) dut (
        .sample_clock(clk),
        .reset       (rst),
        .enable      (en),
        .smp         (smp),
        .dac_bclk    (bclk),
        .dac_lrck    (lrck),
        .dac_data    (data),
        .frame_start (fs),
        .underflow   (uf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard / receiver state
    logic          m_full = 1'b0;
    logic [D-1:0]  m_l = '0, m_r = '0;
    logic          acc_pend = 1'b0, en_e = 1'b0, rst_e = 1'b0;
    logic [D-1:0]  acc_l = '0, acc_r = '0;
    int            acc_count = 0, fs_count = 0, uf_count = 0;
    int            since = 0, fs_gap = -1, cur_k = -1;
    logic          pending = 1'b0, full_before;
    logic [FB-1:0] cur_bits = '0, pend_bits = '0, rx_w, exp_w;
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] rx_log[$];
    logic          prev_bclk = 1'b0, prev_data = 1'b0;
    logic [D-1:0]  tx_l[$], tx_r[$];
    int            acc_fs[$];

    function automatic logic [FB-1:0] pack(input logic [D-1:0] l, input logic [D-1:0] r);
        logic [FB-1:0] w;
        w = '0;
        w[FB-1 -: D] = l;
        w[S-1 -: D]  = r;
        return w;
    endfunction

    always @(posedge clk) begin
        acc_pend <= smp.sample_valid && !m_full && !rst;
        acc_l    <= smp.sample_left;
        acc_r    <= smp.sample_right;
        en_e     <= en;
        rst_e    <= rst;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_e) begin
                m_full = 1'b0; cur_k = -1; pending = 1'b0; exp_q.delete(); since = 0; fs_gap = -1;
                checks++;
                if ({bclk, lrck, data, fs, uf} !== 5'b0 || smp.sample_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_state: bclk/lrck/data/fs/uf=%b ready=%b, required 00000 ready=1",
                             {bclk, lrck, data, fs, uf}, smp.sample_ready);
                end
            end else begin
                full_before = m_full;
                if (en_e) begin
                    since++;
                    if (fs_gap >= 0) fs_gap++;
                end else begin
                    since = 0; fs_gap = -1; cur_k = -1; pending = 1'b0; exp_q.delete();
                    checks++;
                    if ({bclk, lrck, data, fs, uf} !== 5'b0) begin
                        errors++;
                        $display("FAIL idle_outputs: bclk/lrck/data/fs/uf=%b, required 00000",
                                 {bclk, lrck, data, fs, uf});
                    end
                end
                if (fs === 1'b1) begin
                    fs_count++;
                    checks++;
                    if (fs_gap < 0) begin
                        if (since != 2 * DIV) begin
                            errors++;
                            $display("FAIL first_load: %0d cycles after enable, required %0d", since, 2 * DIV);
                        end
                    end else if (fs_gap != FRAME_CYC) begin
                        errors++;
                        $display("FAIL frame_period: %0d cycles, required %0d", fs_gap, FRAME_CYC);
                    end
                    fs_gap = 0;
                    checks++;
                    if (uf !== !full_before) begin
                        errors++;
                        $display("FAIL underflow_at_load: underflow=%b, required %b", uf, !full_before);
                    end
                    if (uf === 1'b1) uf_count++;
                    exp_q.push_back(full_before ? pack(m_l, m_r) : '0);
                    m_full = 1'b0;
                    if (cur_k == FB) begin
                        pending = 1'b1; pend_bits = cur_bits;
                    end else begin
                        pending = 1'b0;
                    end
                    cur_k = 0;
                end else if (uf === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL stray_underflow: underflow=1 without frame_start, required 0");
                end
                if (acc_pend) begin
                    m_full = 1'b1; m_l = acc_l; m_r = acc_r; acc_count++;
                end
                checks++;
                if (smp.sample_ready !== !m_full) begin
                    errors++;
                    $display("FAIL ready: sample_ready=%b, required %b", smp.sample_ready, !m_full);
                end
                // Receiver: I2S bits are sampled on BCLK rising edges.
                if (en_e && bclk === 1'b1 && prev_bclk === 1'b0 && cur_k >= 0) begin
                    checks++;
                    if (lrck !== (cur_k >= S)) begin
                        errors++;
                        $display("FAIL lrck: bit %0d lrck=%b, required %b", cur_k, lrck, cur_k >= S);
                    end
                    if (cur_k == 0) begin
                        if (pending) begin
                            rx_w = {pend_bits[FB-1:1], data};
                            rx_log.push_back(rx_w);
                            pending = 1'b0;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL frame_data: received %h, required no frame", rx_w);
                            end else begin
                                exp_w = exp_q.pop_front();
                                if (rx_w !== exp_w) begin
                                    errors++;
                                    $display("FAIL frame_data: received %h, required %h", rx_w, exp_w);
                                end
                            end
                        end
                    end else if (cur_k < FB) begin
                        cur_bits[FB - cur_k] = data;
                    end
                    cur_k++;
                end
                if (en_e && data !== prev_data) begin
                    checks++;
                    if (!(prev_bclk === 1'b1 && bclk === 1'b0)) begin
                        errors++;
                        $display("FAIL data_edge: dac_data changed with bclk %b->%b, required 1->0",
                                 prev_bclk, bclk);
                    end
                end
            end
            prev_bclk = bclk;
            prev_data = data;
        end
    end

    task automatic idle_inputs();
        smp.sample_valid = 1'b0;
        smp.sample_left  = D'($urandom);
        smp.sample_right = D'($urandom);
    endtask

    task automatic send_all(input int budget);
        int target;
        int waited;
        while (tx_l.size() > 0) begin
            smp.sample_left  = tx_l[0];
            smp.sample_right = tx_r[0];
            smp.sample_valid = 1'b1;
            target = acc_count + 1;
            waited = 0;
            while (acc_count < target && waited < budget) begin
                @(negedge clk); #1;
                waited++;
            end
            if (acc_count < target) begin
                checks++; errors++;
                $display("FAIL accept_timeout: pair not accepted in %0d cycles, required acceptance", budget);
                tx_l.delete(); tx_r.delete();
            end else begin
                acc_fs.push_back(fs_count);
                void'(tx_l.pop_front());
                void'(tx_r.pop_front());
            end
        end
        idle_inputs();
    endtask

    task automatic wait_frames(input int n);
        int target;
        int waited;
        target = fs_count + n;
        waited = 0;
        while (fs_count < target && waited < (n + 4) * FRAME_CYC) begin
            @(negedge clk); #1;
            waited++;
        end
        if (fs_count < target) begin
            checks++; errors++;
            $display("FAIL frame_timeout: %0d of %0d loads seen, required all", n - (target - fs_count), n);
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1; en = 1'b1; idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({bclk, lrck, data, fs, uf} !== 5'b0 || smp.sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b ready=%b, required 00000 ready=1",
                     {bclk, lrck, data, fs, uf}, smp.sample_ready);
        end
        #1 rst = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (bclk === 1'b1) break;
        end
        checks++;
        if (cnt != DIV) begin
            errors++;
            $display("FAIL first_bclk_rise: %0d cycles after release, required %0d", cnt, DIV);
        end
        #1;
    endtask

    task automatic test_basic_frame();
        rx_log.delete();
        tx_l.push_back(16'hA5C3); tx_r.push_back(16'h0F01);
        send_all(2 * FRAME_CYC);
        wait_frames(2);
        repeat (2 * DIV) @(negedge clk);
        #1;
        checks++;
        if (rx_log.size() < 1) begin
            errors++;
            $display("FAIL basic_frame: %0d frames received, required >= 1", rx_log.size());
        end else begin
            if (rx_log[0][FB-1 -: D] !== 16'hA5C3) begin
                errors++;
                $display("FAIL basic_left: got %h, required a5c3", rx_log[0][FB-1 -: D]);
            end
            checks++;
            if (rx_log[0][S-1 -: D] !== 16'h0F01) begin
                errors++;
                $display("FAIL basic_right: got %h, required 0f01", rx_log[0][S-1 -: D]);
            end
        end
    endtask

    task automatic test_underflow();
        int uf0;
        int hits;
        logic [FB-1:0] w;
        uf0 = uf_count;
        wait_frames(3);
        checks++;
        if (uf_count - uf0 != 3) begin
            errors++;
            $display("FAIL underflow_idle: %0d pulses in 3 frames, required 3", uf_count - uf0);
        end
        repeat (100) @(negedge clk);
        #1;
        tx_l.push_back(D'($urandom) | D'(1)); tx_r.push_back(D'($urandom));
        w = pack(tx_l[0], tx_r[0]);
        send_all(FRAME_CYC);
        uf0 = uf_count;
        rx_log.delete();
        wait_frames(2);
        repeat (2 * DIV) @(negedge clk);
        #1;
        checks++;
        if (uf_count - uf0 != 1) begin
            errors++;
            $display("FAIL underflow_after_push: %0d pulses in 2 frames, required 1", uf_count - uf0);
        end
        hits = 0;
        foreach (rx_log[i]) if (rx_log[i] === w) hits++;
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL underflow_recover: pair seen %0d times, required 1", hits);
        end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] sent[3];
        logic [FB-1:0] nz[$];
        rx_log.delete();
        acc_fs.delete();
        for (int i = 0; i < 3; i++) begin
            tx_l.push_back(D'($urandom) | D'(1));
            tx_r.push_back(D'($urandom));
            sent[i] = pack(tx_l[i], tx_r[i]);
        end
        send_all(3 * FRAME_CYC);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_fs.size() != 3) begin
                errors++;
                $display("FAIL accept_count: %0d accepted, required 3", acc_fs.size());
            end else if (acc_fs[i] - acc_fs[0] != i) begin
                errors++;
                $display("FAIL accept_rate: pair %0d accepted %0d loads after first, required %0d",
                         i, acc_fs[i] - acc_fs[0], i);
            end
        end
        wait_frames(3);
        repeat (2 * DIV) @(negedge clk);
        #1;
        foreach (rx_log[i]) if (rx_log[i] != '0) nz.push_back(rx_log[i]);
        checks++;
        if (nz.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d data frames, required 3", nz.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= nz.size()) begin
                errors++;
                $display("FAIL b2b_order: frame %0d missing, required %h", i, sent[i]);
            end else if (nz[i] !== sent[i]) begin
                errors++;
                $display("FAIL b2b_order: frame %0d got %h, required %h", i, nz[i], sent[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [FB-1:0] w;
        wait_frames(1);
        repeat (FRAME_CYC - 1) @(negedge clk);
        #1;
        smp.sample_left  = D'($urandom) | D'(1);
        smp.sample_right = D'($urandom);
        smp.sample_valid = 1'b1;
        w = pack(smp.sample_left, smp.sample_right);
        @(negedge clk);
        checks++;
        if (fs !== 1'b1 || uf !== 1'b1 || smp.sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: fs=%b uf=%b ready=%b, required fs=1 uf=1 ready=0",
                     fs, uf, smp.sample_ready);
        end
        #1 idle_inputs();
        repeat (2 * DIV) @(negedge clk);
        #1 rx_log.delete();
        wait_frames(2);
        repeat (2 * DIV) @(negedge clk);
        #1;
        checks++;
        if (rx_log.size() < 2) begin
            errors++;
            $display("FAIL same_cycle_frames: %0d frames, required 2", rx_log.size());
        end else begin
            if (rx_log[0] !== '0) begin
                errors++;
                $display("FAIL same_cycle_zero: got %h, required 0", rx_log[0]);
            end
            checks++;
            if (rx_log[1] !== w) begin
                errors++;
                $display("FAIL same_cycle_next: got %h, required %h", rx_log[1], w);
            end
        end
    endtask

    task automatic test_disruption();
        logic [FB-1:0] w1;
        logic [FB-1:0] w2;
        int waited;
        int uf0;
        int hits;
        wait_frames(1);
        tx_l.push_back(D'($urandom) | D'(1)); tx_r.push_back(D'($urandom));
        w1 = pack(tx_l[0], tx_r[0]);
        send_all(FRAME_CYC);
        waited = 0;
        while (cur_k != 21 && waited < 2 * FRAME_CYC) begin
            @(negedge clk); #1;
            waited++;
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({bclk, lrck, data} !== 3'b0 || smp.sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL disable: bclk/lrck/data=%b ready=%b, required 000 ready=0",
                     {bclk, lrck, data}, smp.sample_ready);
        end
        repeat (50) @(negedge clk);
        #1 en = 1'b1;
        wait_frames(1);
        rx_log.delete();
        wait_frames(1);
        repeat (2 * DIV) @(negedge clk);
        #1;
        checks++;
        if (rx_log.size() < 1 || rx_log[0] !== w1) begin
            errors++;
            $display("FAIL kept_pair: %0d frames, first %h, required %h",
                     rx_log.size(), rx_log.size() > 0 ? rx_log[0] : '0, w1);
        end
        tx_l.push_back(D'($urandom) | D'(1)); tx_r.push_back(D'($urandom));
        w2 = pack(tx_l[0], tx_r[0]);
        send_all(FRAME_CYC);
        repeat (50) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (smp.sample_ready !== 1'b1 || uf !== 1'b0 || {bclk, lrck, data} !== 3'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b uf=%b bclk/lrck/data=%b, required 1 0 000",
                     smp.sample_ready, uf, {bclk, lrck, data});
        end
        @(negedge clk);
        #1 rst = 1'b0;
        rx_log.delete();
        uf0 = uf_count;
        wait_frames(2);
        repeat (2 * DIV) @(negedge clk);
        #1;
        checks++;
        if (uf_count - uf0 != 2) begin
            errors++;
            $display("FAIL reset_discard_uf: %0d underflows, required 2", uf_count - uf0);
        end
        hits = 0;
        foreach (rx_log[i]) if (rx_log[i] === w2) hits++;
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL reset_discard: discarded pair sent %0d times, required 0", hits);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_frame();
        test_underflow();
        test_back_to_back();
        test_same_cycle();
        test_disruption();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
